// File: rtl/interp_coeff_table_pkg.sv
// interp_coeff_pkg
//   Shared constants for the interpolation coefficient table: IEEE-754
//   single-precision field positions, the clear-sequencer state encoding and
//   a helper that sizes the bank-select field.
package interp_coeff_pkg;

    localparam int         EXP_MSB     = 30;
    localparam int         EXP_LSB     = 23;
    localparam int         MAN_MSB     = 22;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Width of a field that selects one of n banks; never narrower than 1 bit.
    function automatic int bank_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interp_coeff_table_if.sv
// interp_coeff_table_if
//   Bundles the lookup request, result and coefficient-load signals of
//   interp_coeff_table.
//   slave  : the table (consumes requests/loads, drives ready and results)
//   master : the requester (drives requests/loads, observes results)
//   Lookup : in_valid, in_r2 (float r^2), in_tag
//   Result : out_valid, out_coeff (bank k at [k*DATA_WIDTH +: DATA_WIDTH]),
//            out_range_err, out_tag
//   Load   : load_we, load_bank, load_addr, load_data, clear; ready gates both
interface interp_coeff_table_if
    import interp_coeff_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ORDER      = 1,
    parameter int TAG_WIDTH  = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int BANK_W     = bank_bits(ORDER + 1)
);
    logic                            in_valid;
    logic [31:0]                     in_r2;
    logic [TAG_WIDTH-1:0]            in_tag;
    logic                            ready;
    logic                            out_valid;
    logic [(ORDER+1)*DATA_WIDTH-1:0] out_coeff;
    logic                            out_range_err;
    logic [TAG_WIDTH-1:0]            out_tag;
    logic                            load_we;
    logic [BANK_W-1:0]               load_bank;
    logic [ADDR_WIDTH-1:0]           load_addr;
    logic [DATA_WIDTH-1:0]           load_data;
    logic                            clear;

    modport slave (
        input  in_valid, in_r2, in_tag, load_we, load_bank, load_addr, load_data, clear,
        output ready, out_valid, out_coeff, out_range_err, out_tag
    );

    modport master (
        output in_valid, in_r2, in_tag, load_we, load_bank, load_addr, load_data, clear,
        input  ready, out_valid, out_coeff, out_range_err, out_tag
    );

endinterface

// File: rtl/interp_coeff_table_bank.sv
// coeff_bank
//   One coefficient bank: simple dual-port RAM, DATA_WIDTH x DEPTH, with a
//   registered read (1-cycle latency). A same-address read/write in one cycle
//   returns the old word. INIT_FILE_BASE/BANK_IDX name the configuration-time
//   image for the device flow; contents are otherwise set via the write port.
//   clk            : clock
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, rdata valid the cycle after raddr
module coeff_bank #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 12,
    parameter int    DEPTH          = 3584,
    parameter string INIT_FILE_BASE = "",
    parameter int    BANK_IDX       = 0
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    (* ramstyle = "M20K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/interp_coeff_table.sv
// interp_coeff_table
//   Runtime-reloadable, multi-bank coefficient table. A float r^2 is decoded
//   to {segment, bin}; all ORDER+1 coefficients come back 3 cycles later.
//   Out-of-range inputs still read (address 0) but the result is forced to 0
//   with out_range_err set. A clear pulse zeroes every bank over DEPTH cycles
//   while ready is low; lookups and loads offered then are dropped.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : interp_coeff_table_if slave (lookup, result, load, clear)
module interp_coeff_table
    import interp_coeff_pkg::*;
#(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ORDER          = 1,
    parameter int    SEGMENT_NUM    = 14,
    parameter int    BIN_BITS       = 8,
    parameter int    SEG0_EXP       = 114,
    parameter int    TAG_WIDTH      = 16,
    parameter string INIT_FILE_BASE = "c1_"
) (
    input  logic                clk,
    input  logic                rst_n,
    interp_coeff_table_if.slave bus
);

    localparam int SEG_W      = $clog2(SEGMENT_NUM);
    localparam int ADDR_WIDTH = SEG_W + BIN_BITS;
    localparam int DEPTH      = SEGMENT_NUM << BIN_BITS;
    localparam int NB         = ORDER + 1;
    localparam int BANK_W     = bank_bits(NB);
    localparam int STAGES     = 3;

    // ---------------- decode ----------------
    logic [7:0]            exp_f;
    logic [7:0]            seg;
    logic                  range_err;
    logic [ADDR_WIDTH-1:0] lk_addr;

    always_comb begin
        exp_f     = bus.in_r2[EXP_MSB:EXP_LSB];
        seg       = exp_f - 8'(SEG0_EXP);
        // Zero/denormals fall under exp < SEG0_EXP; Inf/NaN are called out
        // explicitly so a wide table can never map them to a segment.
        range_err = bus.in_r2[31]
                 || (int'(exp_f) <  SEG0_EXP)
                 || (int'(exp_f) >= SEG0_EXP + SEGMENT_NUM)
                 || (exp_f == EXP_SPECIAL);
        lk_addr   = range_err ? '0 : {seg[SEG_W-1:0], bus.in_r2[MAN_MSB -: BIN_BITS]};
    end

    logic unused_dec;
    assign unused_dec = ^{seg[7:SEG_W], bus.in_r2[MAN_MSB-BIN_BITS:0]};

    // ---------------- clear sequencer ----------------
    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            ready_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.clear) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                        ready_q    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // Further clear pulses are ignored here.
                    if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                    clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- write-port mux (clear over load) ----------------
    // Inputs go straight to the RAM write port so a load in cycle W lands
    // before the S2 read of a lookup presented in cycle W.
    logic [NB-1:0]         wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        wr_en   = '0;
        wr_addr = bus.load_addr;
        wr_data = bus.load_data;
        if (state_q == ST_CLEAR) begin
            wr_en   = '1;
            wr_addr = clr_addr_q;
            wr_data = '0;
        end else if (bus.load_we) begin
            for (int k = 0; k < NB; k++)
                if (bus.load_bank == BANK_W'(k))
                    wr_en[k] = 1'b1;
        end
    end

    // ---------------- pipeline ----------------
    logic [STAGES-1:0]               vld_pipe_q, vld_pipe_d;
    logic [ADDR_WIDTH-1:0]           s1_addr_q, s1_addr_d;
    logic                            s1_err_q, s1_err_d, s2_err_q, s2_err_d;
    logic [TAG_WIDTH-1:0]            s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic [TAG_WIDTH-1:0]            out_tag_q, out_tag_d;
    logic [NB*DATA_WIDTH-1:0]        out_coeff_q, out_coeff_d;
    logic                            out_err_q, out_err_d;
    logic [NB-1:0][DATA_WIDTH-1:0]   rd_data;

    for (genvar k = 0; k < NB; k++) begin : g_bank
        coeff_bank #(
            .DATA_WIDTH     (DATA_WIDTH),
            .ADDR_WIDTH     (ADDR_WIDTH),
            .DEPTH          (DEPTH),
            .INIT_FILE_BASE (INIT_FILE_BASE),
            .BANK_IDX       (k)
        ) u_bank (
            .clk   (clk),
            .we    (wr_en[k]),
            .waddr (wr_addr),
            .wdata (wr_data),
            .raddr (s1_addr_q),
            .rdata (rd_data[k])
        );
    end

    always_comb begin
        vld_pipe_d  = {vld_pipe_q[STAGES-2:0], bus.in_valid && ready_q};
        s1_addr_d   = lk_addr;
        s1_err_d    = range_err;
        s1_tag_d    = bus.in_tag;
        s2_err_d    = s1_err_q;
        s2_tag_d    = s1_tag_q;
        // Result fields hold between valid outputs.
        out_coeff_d = out_coeff_q;
        out_err_d   = out_err_q;
        out_tag_d   = out_tag_q;
        if (vld_pipe_q[1]) begin
            out_coeff_d = s2_err_q ? '0 : rd_data;
            out_err_d   = s2_err_q;
            out_tag_d   = s2_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            s1_addr_q   <= '0;
            s1_err_q    <= 1'b0;
            s1_tag_q    <= '0;
            s2_err_q    <= 1'b0;
            s2_tag_q    <= '0;
            out_coeff_q <= '0;
            out_err_q   <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            s1_addr_q   <= s1_addr_d;
            s1_err_q    <= s1_err_d;
            s1_tag_q    <= s1_tag_d;
            s2_err_q    <= s2_err_d;
            s2_tag_q    <= s2_tag_d;
            out_coeff_q <= out_coeff_d;
            out_err_q   <= out_err_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.ready         = ready_q;
    assign bus.out_valid     = vld_pipe_q[STAGES-1];
    assign bus.out_coeff     = out_coeff_q;
    assign bus.out_range_err = out_err_q;
    assign bus.out_tag       = out_tag_q;

endmodule

// File: tb/tb_interp_coeff_table.sv
// tb_interp_coeff_table
//   Bench for interp_coeff_table (default parameters, no init files): the
//   table is filled through the load port, a model array tracks contents and
//   a scoreboard queue holds expected results with their due cycle.
module tb_interp_coeff_table;

    localparam int DEPTH = 3584;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    interp_coeff_table_if #(
        .DATA_WIDTH (32),
        .ORDER      (1),
        .TAG_WIDTH  (16),
        .ADDR_WIDTH (12),
        .BANK_W     (1)
    ) bus ();

    interp_coeff_table #(
        .INIT_FILE_BASE ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] coeff;
        logic        err;
        logic [15:0] tag;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] r2;
        logic        err;
        logic [11:0] addr;
    } vec_t;

    exp_t        sbq[$];
    logic [31:0] mdl [0:1][0:DEPTH-1];
    vec_t        vt [13];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pat(input int b, input int a);
        return {4'(b + 1), 4'h5, 12'(a), 12'(a ^ 32'hA5A)};
    endfunction

    function automatic logic [31:0] r2_of(input int a);
        return {1'b0, 8'(114 + a / 256), 8'(a % 256), 15'($urandom)};
    endfunction

    // r^2 -> {err, addr} straight from the field definitions
    function automatic void decode(input logic [31:0] r2, output logic err, output logic [11:0] a);
        int e;
        e   = int'(r2[30:23]);
        err = r2[31] || e < 114 || e >= 128 || e == 255;
        a   = err ? 12'd0 : {4'(e - 114), r2[22:15]};
    endfunction

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.load_we  = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic lookup_exp(input logic [31:0] r2, input logic [15:0] tag,
                              input logic err, input logic [11:0] a);
        exp_t x;
        bus.in_valid = 1'b1;
        bus.in_r2    = r2;
        bus.in_tag   = tag;
        if (bus.ready) begin
            x.coeff = err ? 64'd0 : {mdl[1][a], mdl[0][a]};
            x.err   = err;
            x.tag   = tag;
            x.due   = cyc + 3;
            sbq.push_back(x);
        end
    endtask

    task automatic lookup(input logic [31:0] r2, input logic [15:0] tag);
        logic        err;
        logic [11:0] a;
        decode(r2, err, a);
        lookup_exp(r2, tag, err, a);
    endtask

    task automatic load(input int b, input int a, input logic [31:0] d);
        bus.load_we   = 1'b1;
        bus.load_bank = 1'(b);
        bus.load_addr = 12'(a);
        bus.load_data = d;
        if (bus.ready) mdl[b][a] = d;
    endtask

    task automatic fill_all();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) begin
                load(b, a, pat(b, a));
                step();
            end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d results still outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got tag %h, required no output", bus.out_tag);
            end else begin
                e = sbq.pop_front();
                chk("out_coeff", bus.out_coeff, e.coeff);
                chk("out_range_err", 64'(bus.out_range_err), 64'(e.err));
                chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
                chk("latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vt[0]  = '{32'h3F800000, 1'b0, 12'd3328};
        vt[1]  = '{32'h3F900000, 1'b0, 12'd3360};
        vt[2]  = '{32'h39000000, 1'b0, 12'd0};
        vt[3]  = '{32'h39FF8000, 1'b0, 12'd511};
        vt[4]  = '{32'h3F7FFFFF, 1'b0, 12'd3327};
        vt[5]  = '{32'h3F808000, 1'b0, 12'd3329};
        vt[6]  = '{32'h38800000, 1'b1, 12'd0};
        vt[7]  = '{32'h40000000, 1'b1, 12'd0};
        vt[8]  = '{32'hBF800000, 1'b1, 12'd0};
        vt[9]  = '{32'h7F800000, 1'b1, 12'd0};
        vt[10] = '{32'h00000000, 1'b1, 12'd0};
        vt[11] = '{32'h7FC00000, 1'b1, 12'd0};
        vt[12] = '{32'h00400000, 1'b1, 12'd0};

        idle();
        bus.in_r2 = '0; bus.in_tag = '0;
        bus.load_bank = '0; bus.load_addr = '0; bus.load_data = '0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_coeff", bus.out_coeff, 64'd0);
        chk("rst_out_range_err", 64'(bus.out_range_err), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);

        fill_all();

        // Decode / range table, one lookup per cycle
        for (int i = 0; i < 13; i++) begin
            lookup_exp(vt[i].r2, 16'(i), vt[i].err, vt[i].addr);
            step();
        end
        drain();
        repeat (3) @(negedge clk);
        chk("hold_range_err", 64'(bus.out_range_err), 64'd1);
        chk("hold_coeff_zero", bus.out_coeff, 64'd0);

        // Write in cycle W is seen by a lookup in cycle W
        load(1, 3328, 32'hDEADBEEF);
        lookup(32'h3F800000, 16'h1111);
        step();
        // Write in W+1 is not seen by the lookup in W
        lookup(32'h3F800000, 16'h2222);
        step();
        load(1, 3328, 32'hCAFEF00D);
        step();
        lookup(32'h3F800000, 16'h3333);
        step();
        drain();
        repeat (2) @(negedge clk);
        chk("hold_coeff", bus.out_coeff, {mdl[1][3328], mdl[0][3328]});

        // 100 back-to-back lookups
        for (int i = 0; i < 100; i++) begin
            logic [31:0] r;
            if ($urandom_range(0, 7) == 0) r = $urandom;
            else r = {1'b0, 8'(114 + $urandom_range(0, 13)), 23'($urandom)};
            lookup(r, 16'(16'h4000 + i));
            step();
        end
        drain();

        // Clear: a lookup in the pulse cycle still completes; traffic while
        // clearing is dropped; a second pulse mid-clear is ignored.
        bus.clear = 1'b1;
        lookup(r2_of(3328), 16'h5000);
        step();
        cnt = 0;
        while (!bus.ready && cnt < 5000) begin
            if (cnt == 100) bus.clear = 1'b1;
            if (cnt % 7 == 3) begin
                lookup(r2_of(cnt % DEPTH), 16'h5EEE);
                load(0, 5, 32'h12345678);
            end
            step();
            cnt++;
        end
        chk("clear_ready_low_cycles", 64'(cnt), 64'd3584);
        drain();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) mdl[b][a] = 32'd0;
        lookup(r2_of(5), 16'h6005);
        step();
        for (int i = 0; i < 13; i++) begin
            lookup_exp(vt[i].r2, 16'(16'h6100 + i), vt[i].err, vt[i].addr);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            lookup(r2_of($urandom_range(0, DEPTH - 1)), 16'(16'h6200 + i));
            step();
        end
        drain();

        // Reset in the middle of a clear, just before address 1000 is written
        fill_all();
        bus.clear = 1'b1;
        step();
        repeat (1000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midclear_rst_ready", 64'(bus.ready), 64'd1);
        chk("midclear_rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 1000; a++) mdl[b][a] = 32'd0;
        @(negedge clk);
        lookup(r2_of(0), 16'h7000);   step();
        lookup(r2_of(999), 16'h7001); step();
        lookup(r2_of(1000), 16'h7002); step();
        lookup(r2_of(1500), 16'h7003); step();
        lookup(r2_of(3583), 16'h7004); step();
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interp_coeff_table.md
# interp_coeff_table

Multi-bank, runtime-reloadable coefficient table for the range-limited force interpolation pipeline. It accepts an IEEE-754 single-precision r² per cycle and decodes it into a segment/bin address: each segment is twice as wide as the previous one, with equal bins per segment. It returns all ORDER+1 interpolation coefficients in parallel after a fixed latency, with out-of-range detection and zero forcing. It replaces the per-coefficient lookup memories used by the RL_LJ evaluate-pairs datapath and adds a write port and a hardware clear sequencer.

## Interface
- DATA_WIDTH, 32: coefficient width.
- ORDER, 1: interpolation order; ORDER+1 coefficient banks.
- SEGMENT_NUM, 14: number of segments.
- BIN_BITS, 8: log2 of bins per segment (BIN_NUM = 256).
- SEG0_EXP, 114: biased float exponent mapped to segment 0.
- TAG_WIDTH, 16: sideband tag carried alongside each lookup.
- INIT_FILE_BASE, "c1_": bank k is initialised from INIT_FILE_BASE k ".hex".
- Derived localparams: ADDR_WIDTH = clog2(SEGMENT_NUM)+BIN_BITS (12 by default); DEPTH = SEGMENT_NUM<<BIN_BITS (3584 by default).
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  lookup request.
- in_r2  in  32  r², single precision.
- in_tag  in  TAG_WIDTH  passed through.
- ready  out  1  high when lookups and loads are accepted.
- out_valid  out  1  result valid.
- out_coeff  out  (ORDER+1)*DATA_WIDTH  bank k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_range_err  out  1  r² outside table range; out_coeff is forced to zero.
- out_tag  out  TAG_WIDTH  tag aligned with out_valid.
- load_we  in  1  coefficient write.
- load_bank  in  clog2(ORDER+1) (minimum 1)  target bank.
- load_addr  in  ADDR_WIDTH  target address.
- load_data  in  DATA_WIDTH  write data.
- clear  in  1  single-cycle pulse that starts zeroing all banks.

## Operation
- Address decode:
  - exp = in_r2[30:23]; seg = exp − SEG0_EXP; bin = in_r2[22 -: BIN_BITS].
  - addr = {seg[ADDR_WIDTH-BIN_BITS-1:0], bin}.
- Range error is asserted when any of the following holds: sign bit set, exp < SEG0_EXP (this includes zero and denormals), exp ≥ SEG0_EXP+SEGMENT_NUM, or exp == 255.
- On a range error the read still issues at address 0. The output stage forces out_coeff to 0 and sets out_range_err.
- Pipeline has three registered stages: S1 decode/address register; S2 bank read (registered read in every bank); S3 output register with zero forcing. Fully pipelined; accepts one lookup per cycle.
- Banks are simple dual-port: the read port is used by S2, the write port by load or clear. A load and a lookup may occur in the same cycle.
- Read and write to the same address in the same cycle returns the old data.
- A write issued in cycle W is visible to a lookup presented in cycle W or later.
- Clear FSM:
  - States: IDLE and CLEAR, with a counter clr_addr.
  - IDLE→CLEAR on clear while in IDLE. clr_addr starts at 0, and all banks are written with 0 at clr_addr each cycle.
  - CLEAR→IDLE after writing DEPTH−1.
  - ready = (state == IDLE).
  - A clear pulse received while in CLEAR is ignored.
- While ready = 0: in_valid and load_we are dropped (no out_valid is produced and no write occurs). Lookups already in flight complete normally.
- Reset:
  - Clears all pipeline valids and returns the FSM to IDLE, aborting any clear in progress.
  - Table contents are not affected by reset. They hold the init files at configuration; any prior loads or clear remain.

## Timing
- in_valid accepted in cycle N → out_valid in cycle N+3, with out_tag = in_tag.
- Throughput: 1 lookup per cycle while ready = 1.
- Clear pulse in cycle C → ready low in cycles C+1 through C+DEPTH, then high in cycle C+DEPTH+1.
- Reset values: out_valid 0, out_coeff 0, out_range_err 0, out_tag 0, ready 1 (after rst_n deasserts).
- out_coeff and out_range_err hold their last value while out_valid = 0.

## Structure
- Package interp_coeff_pkg holds the float field constants (EXP_MSB=30, EXP_LSB=23, MAN_MSB=22, EXP_SPECIAL=8'hFF) and the FSM enum {ST_IDLE, ST_CLEAR}.
- Sub-module coeff_bank: a simple dual-port RAM of DATA_WIDTH × DEPTH with 1-cycle registered read, init-file parameter and M20K inference. It is instantiated ORDER+1 times by a generate loop.
- The top level contains the decode, the pipeline valid/tag shift registers, the clear FSM and the write-port mux (clear has priority over load).

## Test plan
- Decode: r2 = 0x3F800000 (1.0) → addr 3328; r2 = 0x3F900000 → addr 3360; r2 = 0x39000000 → addr 0; each output equals the init-file word, 3 cycles later, with out_range_err = 0.
- Range error: 0x38800000, 0x40000000, 0xBF800000, 0x7F800000 → out_valid with out_coeff = 0 and out_range_err = 1.
- Load then lookup: write bank 1 addr 3328 = 0xDEADBEEF in cycle W, lookup of 1.0 in cycle W → bank 1 field = 0xDEADBEEF; a write in cycle W+1 instead → old value.
- Back-to-back: 100 consecutive random lookups → 100 consecutive out_valid with matching tags, each result delayed exactly 3 cycles.
- Clear: pulse clear → ready low for exactly 3584 cycles; lookups and loads issued during clear are dropped; after clear, all lookups return 0.
- Reset mid-clear at count 1000 → ready = 1 and out_valid = 0 immediately; addresses below 1000 read 0 and addresses at or above 1000 read their prior contents.
